fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the asynchronous FIFO among `NREQ` requesters in the write clock domain. It grants the port round-robin in bursts of up to `MAX_BURST` words and drives `w_en`/`wdata` into the FIFO write-pointer/memory path. It honours the FIFO `full` flag so that no accepted word is ever dropped.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters (≥2)
- `DATA_WIDTH`, 8 — FIFO word width
- `MAX_BURST`, 4 — maximum words per grant (≥1)

Ports:
- `wclk`  in  1  write-domain clock; all logic on rising edge
- `wrst`  in  1  synchronous, active-high reset
- `req`  in  NREQ  per-requester valid; level, held with data until acked
- `req_data`  in  NREQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `full`  in  1  FIFO full flag from write-pointer logic
- `ack`  out  NREQ  one-hot; `ack[i]`=1 means requester i's word is written this cycle
- `w_en`  out  1  FIFO write enable
- `wdata`  out  DATA_WIDTH  FIFO write data
- `busy`  out  1  burst in progress (state BURST)
- `owner`  out  $clog2(NREQ)  index of current/last granted requester

## Operation
- Registers: `state` {IDLE, BURST}, `owner`, `rr_ptr` ($clog2(NREQ)), `beats` ($clog2(MAX_BURST+1)).
- IDLE: if `req`≠0, select first set bit searching upward from `rr_ptr` with wrap (rr_ptr, rr_ptr+1 … NREQ-1, 0 …); load `owner`, clear `beats`, go BURST. If `req`=0, stay. No writes in IDLE.
- BURST (combinational outputs): `w_en` = `req[owner]` & ~`full`; `wdata` = `req_data` slice of `owner`; `ack` = `w_en` << `owner`. `ack`/`w_en` never asserted for a non-owner.
- Each cycle with `w_en`=1: `beats` += 1.
- Burst ends (go IDLE, `rr_ptr` ← `owner`+1 mod NREQ) when either:
  - `w_en`=1 and `beats`+1 == MAX_BURST (last word written this cycle), or
  - `req[owner]`=0 (requester withdrew; no write that cycle).
- `full`=1 in BURST: stall; no write, `beats` held, grant kept while `req[owner]`=1. No timeout.
- `full` is trusted as-is: a write issued while `full`=0 is always accepted by the FIFO (its full flag already accounts for the write in flight).
- `wdata` outside BURST: all zeros. `owner` holds its last value in IDLE.
- Requester i must not change `req_data` slice while `req[i]`=1 and `ack[i]`=0.
- Non-power-of-two NREQ: `rr_ptr`/`owner` wrap from NREQ-1 to 0.

## Timing
- Reset (`wrst`=1 at edge): state IDLE, `owner`=0, `rr_ptr`=0, `beats`=0; hence `ack`=0, `w_en`=0, `wdata`=0, `busy`=0. Reset mid-burst aborts the burst; the word of the reset cycle is not written (outputs forced low while `wrst`=1).
- Grant latency: `req` seen in IDLE at edge N → BURST from N+1; first `w_en` in cycle N+1 if `full`=0.
- Back-to-back bursts: one idle arbitration cycle between bursts (including same requester re-granted).
- Throughput: MAX_BURST words per MAX_BURST+1 cycles under continuous requests and no `full`.
- `req[owner]` dropping and `full` rising in the same cycle: burst ends (withdrawal wins).

## Test plan
- Reset: `wrst`=1 two cycles with `req`=4'b1111 → `w_en`=0, `ack`=0, `busy`=0, `owner`=0; first grant after release to requester 0.
- Single requester 1 holds `req` for 6 words, MAX_BURST=4, `full`=0 → `ack[1]` for 4 consecutive cycles, 1 idle cycle, 2 more words; `wdata` sequence matches the 6 words in order.
- All four requesting continuously → grant order 0,1,2,3,0, each burst exactly 4 writes, 5-cycle period.
- Requester 2 finishes, then `req`=4'b1001 → next grant to 3, then 0 (rr_ptr=3 after 2).
- `full`=1 for 3 cycles mid-burst after 2 words → `w_en`=0 for those 3 cycles, `busy`=1, `beats`=2 held; remaining 2 words written after `full` falls, no word lost or duplicated.
- Owner drops `req` after 1 word; separately, `wrst` asserted mid-burst → burst ends with no write that cycle, `rr_ptr` advances; reset returns all outputs to 0 next cycle and `rr_ptr`=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters,
// granting bursts of up to MAX_BURST words and stalling on the FIFO full flag.
module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                       wclk,
  input  logic                       wrst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic                       full,
  output logic [NREQ-1:0]            ack,
  output logic                       w_en,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    owner
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   owner_reg, owner_next;
  logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0]   beats_reg, beats_next;

  logic [DATA_WIDTH-1:0] req_word [NREQ];
  logic [NREQ-1:0]       owner_onehot;
  logic [PW-1:0]         pick;
  logic [PW-1:0]         scan_idx;
  logic [PW-1:0]         owner_inc;
  logic                  pick_valid;
  logic                  owner_req;
  logic                  last_beat;
  int                    scan_sum;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_word[gi]     = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign owner_onehot[gi] = (owner_reg == PW'(gi));
    end
  endgenerate

  assign owner_req = |(req & owner_onehot);
  assign last_beat = (beats_reg == BW'(MAX_BURST - 1));
  assign owner_inc = (owner_reg == PW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
  assign owner     = owner_reg;

  // Scan from the farthest offset down so the nearest set bit at or after rr_ptr wins.
  always_comb begin
    pick       = rr_ptr_reg;
    pick_valid = 1'b0;
    scan_sum   = 0;
    scan_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_sum = int'(rr_ptr_reg) + k;
      if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
      scan_idx = PW'(scan_sum);
      if (req[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    beats_next  = beats_reg;
    w_en        = 1'b0;
    wdata       = '0;
    busy        = 1'b0;
    ack         = '0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          owner_next = pick;
          beats_next = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        busy  = 1'b1;
        wdata = req_word[owner_reg];
        w_en  = owner_req & ~full;
        // Withdrawal ends the burst even when full is also high.
        if (!owner_req) begin
          state_next  = IDLE;
          rr_ptr_next = owner_inc;
        end else if (w_en) begin
          beats_next = beats_reg + 1'b1;
          if (last_beat) begin
            state_next  = IDLE;
            rr_ptr_next = owner_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // The word presented during a reset cycle must never reach the FIFO.
    if (wrst) begin
      w_en  = 1'b0;
      wdata = '0;
      busy  = 1'b0;
    end
    ack = w_en ? owner_onehot : '0;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      beats_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      beats_reg  <= beats_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester word queues drive the
// DUT, and a cycle model built from the grant/burst rules predicts every output.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic                 wclk = 1'b0;
  logic                 wrst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic                 full = 1'b0;
  logic [NREQ-1:0]      ack;
  logic                 w_en;
  logic [DW-1:0]        wdata;
  logic                 busy;
  logic [1:0]           owner;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .full(full),
    .ack(ack), .w_en(w_en), .wdata(wdata), .busy(busy), .owner(owner)
  );

  int n_vec = 0;
  int n_err = 0;

  // Requester side: each requester offers the head of its own word queue.
  logic [DW-1:0] dq [NREQ][$];
  bit            hold_off [NREQ];

  // Reference model state.
  bit m_busy = 0;
  int m_owner = 0;
  int m_rr = 0;
  int m_cnt = 0;

  logic [NREQ-1:0] exp_ack;
  logic            exp_wen;
  logic [DW-1:0]   exp_wdata;
  logic            exp_busy;
  logic [15:0]     exp_v, got_v;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (dq[i].size() > 0) && !hold_off[i];
      req_data[i*DW +: DW] = (dq[i].size() > 0) ? dq[i][0] : '0;
    end
  endtask

  task automatic tick_eval();
    drive();
    @(negedge wclk);
    exp_ack   = '0;
    exp_wen   = 1'b0;
    exp_wdata = '0;
    exp_busy  = 1'b0;
    if (!wrst && m_busy) begin
      exp_busy  = 1'b1;
      exp_wdata = (dq[m_owner].size() > 0) ? dq[m_owner][0] : '0;
      exp_wen   = req[m_owner] && !full;
      if (exp_wen) exp_ack[m_owner] = 1'b1;
    end
    exp_v = {exp_busy, exp_wen, exp_ack, exp_wdata, wrst ? 2'b00 : 2'(m_owner)};
    got_v = {busy, w_en, ack, wdata, wrst ? 2'b00 : owner};
  endtask

  task automatic end_burst();
    m_busy = 0;
    m_rr   = (m_owner + 1) % NREQ;
  endtask

  task automatic tick_commit();
    bit found;
    found = 0;
    if (wrst) begin
      m_busy = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[(m_rr + k) % NREQ]) begin
          found   = 1;
          m_owner = (m_rr + k) % NREQ;
        end
      end
      if (found) begin
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (!req[m_owner]) begin
      end_burst();
    end else if (exp_wen) begin
      void'(dq[m_owner].pop_front());
      m_cnt++;
      if (m_cnt == MB) end_burst();
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) begin
      dq[i].delete();
      hold_off[i] = 0;
    end
    full = 1'b0;
    wrst = 1'b1;
    tick_eval(); tick_commit();
    tick_eval(); tick_commit();
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) for (int j = 0; j < 8; j++) dq[i].push_back(DW'($urandom));
    wrst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick_eval();
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %h required %h", c, got_v, exp_v);
      end
      tick_commit();
    end
    wrst = 1'b0;
    for (int c = 2; c < 5; c++) begin
      tick_eval();
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %h required %h", c, got_v, exp_v);
      end
      if (c == 2) begin
        n_vec++;
        if ({busy, w_en, ack, owner} !== 8'h00) begin
          n_err++;
          $display("FAIL reset_idle: got busy/wen/ack/owner %h required 00", {busy, w_en, ack, owner});
        end
      end
      if (c == 3) begin
        n_vec++;
        if (ack !== 4'b0001) begin
          n_err++;
          $display("FAIL reset_first_grant: got ack %b required 0001", ack);
        end
      end
      tick_commit();
    end
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] sent [$];
    logic [DW-1:0] seen [$];
    do_reset();
    for (int j = 0; j < 6; j++) begin
      sent.push_back(DW'($urandom));
      dq[1].push_back(sent[j]);
    end
    for (int c = 0; c < 10; c++) begin
      tick_eval();
      if (w_en) seen.push_back(wdata);
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL single cyc%0d: got %h required %h", c, got_v, exp_v);
      end
      tick_commit();
    end
    n_vec++;
    if (seen.size() != 6 || seen != sent) begin
      n_err++;
      $display("FAIL single_words: got %0d words required 6 in order", seen.size());
    end
  endtask

  task automatic test_all_four();
    int order [$];
    int writes;
    bit prev;
    writes = 0;
    prev = 0;
    do_reset();
    for (int i = 0; i < NREQ; i++) for (int j = 0; j < 40; j++) dq[i].push_back(DW'($urandom));
    for (int c = 0; c < 25; c++) begin
      tick_eval();
      if (w_en && !prev) order.push_back(int'(owner));
      prev = w_en;
      if (c >= 1 && c <= 20 && w_en) writes++;
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL all4 cyc%0d: got %h required %h", c, got_v, exp_v);
      end
      tick_commit();
    end
    n_vec++;
    if (writes != 16) begin
      n_err++;
      $display("FAIL all4_throughput: got %0d writes required 16", writes);
    end
    n_vec++;
    if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
      n_err++;
      $display("FAIL all4_order: got %p required 0,1,2,3,0", order);
    end
  endtask

  task automatic test_rr_skip();
    int order [$];
    bit prev;
    prev = 0;
    do_reset();
    for (int j = 0; j < 4; j++) dq[2].push_back(DW'($urandom));
    for (int c = 0; c < 18; c++) begin
      if (c == 5) for (int j = 0; j < 8; j++) begin
        dq[0].push_back(DW'($urandom));
        dq[3].push_back(DW'($urandom));
      end
      tick_eval();
      if (w_en && !prev) order.push_back(int'(owner));
      prev = w_en;
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL rr_skip cyc%0d: got %h required %h", c, got_v, exp_v);
      end
      tick_commit();
    end
    n_vec++;
    if (order.size() < 3 || order[0] != 2 || order[1] != 3 || order[2] != 0) begin
      n_err++;
      $display("FAIL rr_skip_order: got %p required 2,3,0", order);
    end
  endtask

  task automatic test_full_stall();
    logic [DW-1:0] sent [$];
    logic [DW-1:0] seen [$];
    do_reset();
    for (int j = 0; j < 4; j++) begin
      sent.push_back(DW'($urandom));
      dq[0].push_back(sent[j]);
    end
    for (int c = 0; c < 10; c++) begin
      full = (c >= 3 && c <= 5);
      tick_eval();
      if (w_en) seen.push_back(wdata);
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL stall cyc%0d: got %h required %h", c, got_v, exp_v);
      end
      if (c >= 3 && c <= 5) begin
        n_vec++;
        if (w_en !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL stall_hold cyc%0d: got wen=%b busy=%b required wen=0 busy=1", c, w_en, busy);
        end
      end
      tick_commit();
    end
    full = 1'b0;
    n_vec++;
    if (seen != sent) begin
      n_err++;
      $display("FAIL stall_words: got %0d words required 4 in order", seen.size());
    end
  endtask

  task automatic test_withdraw_and_reset();
    int order [$];
    bit prev;
    prev = 0;
    do_reset();
    dq[1].push_back(DW'($urandom));
    for (int c = 0; c < 16; c++) begin
      if (c == 3) for (int j = 0; j < 10; j++) dq[2].push_back(DW'($urandom));
      wrst = (c == 6);
      if (c == 7) begin
        dq[2].delete();
        for (int j = 0; j < 3; j++) begin
          dq[1].push_back(DW'($urandom));
          dq[3].push_back(DW'($urandom));
        end
      end
      tick_eval();
      if (c >= 7 && w_en && !prev) order.push_back(int'(owner));
      prev = w_en;
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL wdraw_rst cyc%0d: got %h required %h", c, got_v, exp_v);
      end
      if (c == 7) begin
        n_vec++;
        if ({busy, w_en, ack, wdata, owner} !== 16'h0000) begin
          n_err++;
          $display("FAIL post_reset_outputs: got %h required 0000", {busy, w_en, ack, wdata, owner});
        end
      end
      tick_commit();
    end
    wrst = 1'b0;
    n_vec++;
    if (order.size() < 1 || order[0] != 1) begin
      n_err++;
      $display("FAIL post_reset_grant: got %p required first owner 1", order);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (dq[i].size() < 3 && $urandom_range(0, 3) == 0) dq[i].push_back(DW'($urandom));
        hold_off[i] = ($urandom_range(0, 9) == 0);
      end
      full = ($urandom_range(0, 3) == 0);
      wrst = ($urandom_range(0, 49) == 0);
      tick_eval();
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h required %h", c, got_v, exp_v);
      end
      tick_commit();
    end
    wrst = 1'b0;
    full = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) hold_off[i] = 0;
    @(posedge wclk);
    #1;
    test_reset();
    test_single_burst();
    test_all_four();
    test_rr_skip();
    test_full_stall();
    test_withdraw_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
